child_rr_scheduler: RTL and testbench



---
 rtl/child_rr_scheduler_pkg.sv | 24 ++
 rtl/child_rr_scheduler_if.sv | 47 ++++
 rtl/child_rr_scheduler_rr_pick.sv | 51 +++++
 rtl/child_rr_scheduler.sv | 162 ++++++++++++++++
 tb/tb_child_rr_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/child_rr_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// child_sched_pkg
// Shared definitions for the child round-robin scheduler and its picker:
//   - sched_state_e : FSM state encoding (IDLE, GRANT)
//   - DEF_*         : default parameter values used by the scheduler slice
//   - ptr_width()   : width of an index/pointer into an N-entry request vector
// -----------------------------------------------------------------------------
package child_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_e;

  localparam int DEF_N_REQ     = 5;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 4;

  // Width needed to hold an index 0..n-1; never less than one bit.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/child_rr_scheduler_if.sv
// -----------------------------------------------------------------------------
// child_rr_scheduler_if
// Bundle between the child instances (request side), the scheduler and the
// shared downstream resource.
//   req       [N_REQ]        per-child request, held while beats remain
//   req_last  [N_REQ]        per-child final-beat marker of the current burst
//   req_data  [N_REQ*DATA_W] per-child payload, child i at [i*DATA_W +: DATA_W]
//   gnt       [N_REQ]        one-hot grant, zero when idle
//   out_valid/out_data/out_last  beat toward the shared resource
//   out_ready                shared resource accepts the beat
//   busy                     a grant is active
//
// Handshake: a beat transfers on every clock edge where out_valid and
// out_ready are both high. out_valid never waits on out_ready, and while
// out_valid is high without out_ready the beat (out_data/out_last/gnt) is
// held unchanged as long as the granted child keeps its request up.
//
// Modports: slave = scheduler side, master = children/resource side.
// -----------------------------------------------------------------------------
interface child_rr_scheduler_if
  import child_sched_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int DATA_W = DEF_DATA_W
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        gnt;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic                    out_last;
  logic                    out_ready;
  logic                    busy;

  modport slave (
    input  req, req_last, req_data, out_ready,
    output gnt, out_valid, out_data, out_last, busy
  );

  modport master (
    output req, req_last, req_data, out_ready,
    input  gnt, out_valid, out_data, out_last, busy
  );

endinterface

// File: rtl/child_rr_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational one-hot round-robin priority picker. Selects the first set
// bit of i_req at or after position i_ptr, wrapping modulo N.
//   i_req  [N]      request vector
//   i_ptr  [PTR_W]  highest-priority position (expected 0..N-1)
//   o_gnt  [N]      one-hot winner, zero if no request
//   o_idx  [PTR_W]  binary index of the winner (0 if no request)
//   o_any           at least one request present
// -----------------------------------------------------------------------------
module rr_pick
  import child_sched_pkg::*;
#(
  parameter int N     = DEF_N_REQ,
  parameter int PTR_W = ptr_width(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_hi;
  logic [N-1:0] w_src;
  logic [N-1:0] w_oh;

  // Split the search in two: requests at/after the pointer win first; if none
  // exist the lowest request overall is the wrapped-around winner. The lowest
  // set bit of the chosen half is isolated with x & -x.
  always_comb begin
    w_mask = '0;
    for (int k = 0; k < N; k++) begin
      w_mask[k] = (PTR_W'(k) >= i_ptr);
    end
    w_hi  = i_req & w_mask;
    w_src = (|w_hi) ? w_hi : i_req;
    w_oh  = w_src & (~w_src + 1'b1);
    o_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (w_oh[k]) begin
        o_idx = PTR_W'(k);
      end
    end
  end

  assign o_gnt = w_oh;
  assign o_any = |i_req;

endmodule

// File: rtl/child_rr_scheduler.sv
// -----------------------------------------------------------------------------
// child_rr_scheduler
// Shares one downstream transfer channel among N_REQ child instances. One
// child at a time is granted, the grant lasts for at most MAX_BURST accepted
// beats (or until the child marks its last beat or drops its request), and
// priority rotates to the child after the one just served.
//
// Ports:
//   clk             clock
//   rst             asynchronous, active-high reset
//   bus             child_rr_scheduler_if.slave (requests, payloads, beat out)
//   o_dbg_state     current FSM state
//   o_dbg_rr_ptr    round-robin pointer (next highest-priority child)
//   o_dbg_beat_cnt  accepted beats in the current burst
// -----------------------------------------------------------------------------
module child_rr_scheduler
  import child_sched_pkg::*;
#(
  parameter  int N_REQ     = DEF_N_REQ,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int MAX_BURST = DEF_MAX_BURST,
  localparam int PTR_W     = ptr_width(N_REQ),
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                clk,
  input  logic                rst,
  child_rr_scheduler_if.slave bus,
  output sched_state_e        o_dbg_state,
  output logic [PTR_W-1:0]    o_dbg_rr_ptr,
  output logic [CNT_W-1:0]    o_dbg_beat_cnt
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  sched_state_e     r_state,    w_state_nxt;
  logic [N_REQ-1:0] r_gnt,      w_gnt_nxt;
  logic [PTR_W-1:0] r_gidx,     w_gidx_nxt;
  logic [PTR_W-1:0] r_rr_ptr,   w_rr_ptr_nxt;
  logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;

  // ---------------------------------------------------------------------------
  // Arbitration (only consulted in IDLE)
  // ---------------------------------------------------------------------------
  logic [N_REQ-1:0] w_pick_gnt;
  logic [PTR_W-1:0] w_pick_idx;
  logic             w_pick_any;

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .i_req (bus.req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // ---------------------------------------------------------------------------
  // Granted-child mux: request, last marker and payload of child r_gidx
  // ---------------------------------------------------------------------------
  logic              w_req_g;
  logic              w_last_g;
  logic [DATA_W-1:0] w_data_g;

  always_comb begin
    w_req_g  = 1'b0;
    w_last_g = 1'b0;
    w_data_g = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_gidx == PTR_W'(k)) begin
        w_req_g  = bus.req[k];
        w_last_g = bus.req_last[k];
        w_data_g = bus.req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Beat outputs: purely combinational from the registered grant
  // ---------------------------------------------------------------------------
  logic w_in_grant;
  logic w_cnt_max;
  logic w_valid;
  logic w_last;
  logic w_fire;
  logic w_burst_end;

  assign w_in_grant = (r_state == GRANT);
  assign w_cnt_max  = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
  assign w_valid    = w_in_grant & w_req_g;
  assign w_last     = w_in_grant & (w_last_g | w_cnt_max);
  assign w_fire     = w_valid & bus.out_ready;
  // A dropped request abandons the burst without a beat; otherwise the burst
  // closes on the accepted beat that carries out_last.
  assign w_burst_end = w_in_grant & (~w_req_g | (w_fire & w_last));

  assign bus.gnt       = r_gnt;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_in_grant ? w_data_g : '0;
  assign bus.out_last  = w_last;
  assign bus.busy      = w_in_grant;

  assign o_dbg_state    = r_state;
  assign o_dbg_rr_ptr   = r_rr_ptr;
  assign o_dbg_beat_cnt = r_beat_cnt;

  // ---------------------------------------------------------------------------
  // FSM: next-state / register updates
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_gidx_nxt     = r_gidx;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state_nxt    = GRANT;
          w_gnt_nxt      = w_pick_gnt;
          w_gidx_nxt     = w_pick_idx;
          w_beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (w_fire) begin
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
        end
        if (w_burst_end) begin
          // Always pass through IDLE: this gives the one-cycle bubble and
          // lets non-granted requests be re-arbitrated from a fresh pointer.
          w_state_nxt  = IDLE;
          w_gnt_nxt    = '0;
          w_rr_ptr_nxt = (r_gidx == PTR_W'(N_REQ - 1)) ? '0 : r_gidx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_gidx     <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gidx     <= w_gidx_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_child_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_child_rr_scheduler
// Children are modelled as packet sources: each holds a list of payload beats,
// a packet length (req_last on the final beat) and a stop point (req drops
// there; stop < length means the child abandons). When a scenario is loaded,
// the expected beat stream is computed in transaction terms: visit children
// round-robin from the pointer, each visit taking up to MAX_BURST beats and
// ending early on the packet's last beat or the stop point.
// -----------------------------------------------------------------------------
module tb_child_rr_scheduler;
  import child_sched_pkg::*;

  localparam int N_REQ     = 5;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int PTR_W     = 3;
  localparam int CNT_W     = 3;
  localparam int EXP_W     = 4 + DATA_W + 1;
  localparam int MAX_LEN   = 16;
  localparam int LIMIT     = 3000;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  child_rr_scheduler_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  sched_state_e     dbg_state;
  logic [PTR_W-1:0] dbg_rr_ptr;
  logic [CNT_W-1:0] dbg_beat_cnt;

  child_rr_scheduler #(
    .N_REQ     (N_REQ),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .o_dbg_state    (dbg_state),
    .o_dbg_rr_ptr   (dbg_rr_ptr),
    .o_dbg_beat_cnt (dbg_beat_cnt)
  );

  // ---------------------------------------------------------------------------
  // Bench state
  // ---------------------------------------------------------------------------
  int                checks = 0;
  int                errors = 0;
  logic [EXP_W-1:0]  exp_q[$];
  int                model_ptr = 0;

  int                pkt_len  [N_REQ];
  int                pkt_stop [N_REQ];
  int                pkt_pos  [N_REQ];
  logic [DATA_W-1:0] pkt_data [N_REQ][MAX_LEN];
  int                acc_child = -1;
  int                ready_mode = 0;  // 0: always ready, 1: random, 2: pattern
  int                ready_pat[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: children and resource update just after each rising edge
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    #1;
    if (acc_child >= 0) begin
      pkt_pos[acc_child]++;
      acc_child = -1;
    end
    for (int i = 0; i < N_REQ; i++) begin
      bus.req[i]      = (pkt_pos[i] < pkt_stop[i]);
      bus.req_last[i] = (pkt_pos[i] == pkt_len[i] - 1);
      bus.req_data[i*DATA_W +: DATA_W] =
        (pkt_pos[i] < MAX_LEN) ? pkt_data[i][pkt_pos[i]] : DATA_W'($urandom);
    end
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = (ready_pat.size() != 0) ? (ready_pat.pop_front() != 0) : 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard: samples on the falling edge
  // ---------------------------------------------------------------------------
  logic              prev_stall = 1'b0;
  logic              prev_end   = 1'b0;
  logic [N_REQ-1:0]  prev_gnt;
  logic [DATA_W-1:0] prev_data;

  always @(negedge clk) begin
    int               gi;
    logic [EXP_W-1:0] got;
    logic [EXP_W-1:0] exp;
    if (rst) begin
      prev_stall = 1'b0;
      prev_end   = 1'b0;
    end else begin
      if (prev_end) chk("bubble_after_burst", bus.busy, 1'b0);
      if (prev_stall) begin
        chk("stall_valid_held", bus.out_valid, 1'b1);
        chk("stall_gnt_held", bus.gnt, prev_gnt);
        chk("stall_data_held", bus.out_data, prev_data);
      end
      if (bus.out_valid) chk("valid_gnt_onehot", $onehot(bus.gnt), 1'b1);
      prev_end   = 1'b0;
      prev_stall = 1'b0;
      gi = 0;
      for (int i = 0; i < N_REQ; i++) if (bus.gnt[i]) gi = i;
      if (bus.out_valid && bus.out_ready) begin
        got = {4'(gi), bus.out_data, bus.out_last};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected got=%0h expected=none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL beat {child,data,last} got=%0h expected=%0h", got, exp);
          end
        end
        acc_child = gi;
        prev_end  = bus.out_last;
      end else if (bus.out_valid) begin
        prev_stall = 1'b1;
        prev_gnt   = bus.gnt;
        prev_data  = bus.out_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model and scenario helpers
  // ---------------------------------------------------------------------------
  task automatic load_child(input int c, input int len, input int stop);
    pkt_len[c]  = len;
    pkt_stop[c] = stop;
    pkt_pos[c]  = 0;
    for (int b = 0; b < MAX_LEN; b++) pkt_data[c][b] = DATA_W'($urandom);
  endtask

  task automatic clear_children();
    for (int i = 0; i < N_REQ; i++) begin
      pkt_len[i]  = 0;
      pkt_stop[i] = 0;
      pkt_pos[i]  = 0;
    end
  endtask

  task automatic model_build();
    int   pos[N_REQ];
    int   p;
    int   g;
    logic last;
    p = model_ptr;
    for (int i = 0; i < N_REQ; i++) pos[i] = pkt_pos[i];
    while (1) begin
      g = -1;
      for (int k = 0; k < N_REQ; k++) begin
        if (g < 0 && pos[(p + k) % N_REQ] < pkt_stop[(p + k) % N_REQ]) g = (p + k) % N_REQ;
      end
      if (g < 0) break;
      for (int b = 0; b < MAX_BURST; b++) begin
        if (pos[g] >= pkt_stop[g]) break;
        last = (pos[g] == pkt_len[g] - 1) || (b == MAX_BURST - 1);
        exp_q.push_back({4'(g), pkt_data[g][pos[g]], last});
        pos[g]++;
        if (last) break;
      end
      p = (g + 1) % N_REQ;
    end
    model_ptr = p;
  endtask

  function automatic bit children_idle();
    bit idle = (acc_child < 0);
    for (int i = 0; i < N_REQ; i++) if (pkt_pos[i] < pkt_stop[i]) idle = 0;
    return idle;
  endfunction

  task automatic wait_done(input string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || !children_idle() || bus.busy) && cyc < LIMIT) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    chk({"done_in_time_", name}, (cyc < LIMIT), 1'b1);
    @(negedge clk);
    chk({"rr_ptr_", name}, dbg_rr_ptr, model_ptr);
    chk({"idle_gnt_", name}, bus.gnt, '0);
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int cyc;
    int len;
    rst           = 1'b1;
    bus.req       = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    clear_children();
    repeat (3) @(negedge clk);
    chk("rst_gnt", bus.gnt, '0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rr_ptr", dbg_rr_ptr, '0);
    chk("rst_state", dbg_state, IDLE);
    chk("rst_beat_cnt", dbg_beat_cnt, '0);
    rst = 1'b0;
    @(negedge clk);

    // Fairness: all five children, three full bursts each
    ready_mode = 0;
    for (int i = 0; i < N_REQ; i++) load_child(i, 12, 12);
    model_build();
    wait_done("fairness");

    // Single requester: child 2, three beats, grant one cycle after req
    load_child(2, 3, 3);
    model_build();
    @(negedge clk);
    chk("single_gnt_req_cycle", bus.gnt, '0);
    @(negedge clk);
    chk("single_gnt_next_cycle", bus.gnt, 5'b00100);
    chk("single_valid_next_cycle", bus.out_valid, 1'b1);
    wait_done("single");
    chk("single_rr_ptr_is_3", dbg_rr_ptr, 3'd3);

    // Backpressure: child 1, ready pattern 1,0,0,1 after the grant
    ready_mode = 2;
    ready_pat.delete();
    load_child(1, 3, 3);
    model_build();
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.gnt != 5'b00010 && cyc < 50);
    chk("bp_grant", bus.gnt, 5'b00010);
    ready_pat.push_back(1);
    ready_pat.push_back(0);
    ready_pat.push_back(0);
    ready_pat.push_back(1);
    repeat (5) @(negedge clk);
    chk("bp_beat_cnt", dbg_beat_cnt, 3'd2);
    chk("bp_still_granted", bus.gnt, 5'b00010);
    ready_mode = 0;
    wait_done("backpressure");

    // Abandon: child 3 drops its request after one beat
    load_child(3, 3, 1);
    model_build();
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    chk("abandon_beat_seen", (cyc < 50), 1'b1);
    @(negedge clk);
    chk("abandon_drop_valid", bus.out_valid, 1'b0);
    chk("abandon_drop_gnt", bus.gnt, 5'b01000);
    @(negedge clk);
    chk("abandon_released", bus.gnt, '0);
    chk("abandon_busy", bus.busy, 1'b0);
    chk("abandon_rr_ptr", dbg_rr_ptr, 3'd4);
    wait_done("abandon");

    // Wrap: pointer at 4, children 4 and 0 requesting
    load_child(4, 2, 2);
    load_child(0, 2, 2);
    model_build();
    wait_done("wrap");

    // Reset in the middle of a burst from child 0
    load_child(0, 4, 4);
    model_build();
    cyc = 0;
    while (exp_q.size() > 3 && cyc < 50) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    chk("rstmid_first_beat", (cyc < 50), 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("rstmid_gnt", bus.gnt, '0);
    chk("rstmid_valid", bus.out_valid, 1'b0);
    chk("rstmid_busy", bus.busy, 1'b0);
    chk("rstmid_rr_ptr", dbg_rr_ptr, '0);
    exp_q.delete();
    clear_children();
    acc_child = -1;
    model_ptr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_child(0, 2, 2);
    load_child(2, 2, 2);
    model_build();
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_regrant_child0", bus.gnt, 5'b00001);
    wait_done("after_reset");

    // Randomised rounds: random packets, random abandons, random ready
    for (int r = 0; r < 12; r++) begin
      ready_mode = 1;
      for (int i = 0; i < N_REQ; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          len = $urandom_range(1, 10);
          load_child(i, len, ($urandom_range(0, 2) == 0) ? $urandom_range(0, len) : len);
        end
      end
      model_build();
      wait_done("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
